// File: rtl/multicycle_main_control_pkg.sv
// Shared types and encodings for the multicycle RV32I main control FSM.
// The datapath mux selects and ALU op codes are defined here so every user agrees on them.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        JAL,
        ALUWB,
        BEQ
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // States that stall on the memory handshake and are guarded by the watchdog.
    function automatic logic is_mem_wait(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bus between the main control FSM and the multicycle datapath.
// master = the controller, slave = the datapath side that supplies opcode and status.
interface multicycle_main_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal_instr;
    logic       mem_err;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, aluop,
               instr_done, illegal_instr, mem_err
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, aluop,
               instr_done, illegal_instr, mem_err
    );
endinterface

// File: rtl/multicycle_main_control_mem_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles and flags the last allowed one.
// MEM_TIMEOUT = 0 removes the counter entirely and expired stays low.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_wdog
            localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

            logic [W-1:0] count_q;
            logic [W-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (enable) begin
                    count_d = count_q + W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired = (count_q == LAST);
        end else begin : g_off
            logic unused_ok;
            assign unused_ok = ^{clk, rst_n, clear, enable};
            assign expired   = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/memory/writeback
// sequencing with a memory-ready stall and a watchdog abort back to FETCH.
module multicycle_main_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    multicycle_main_control_if.master  bus
);

    state_t state_q;
    state_t state_d;

    logic expired;
    logic waiting;
    logic abort;
    logic pc_update;
    logic branch;

    assign waiting = is_mem_wait(state_q) && !bus.mem_ready;
    assign abort   = waiting && expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((state_d != state_q) || abort),
        .enable  (waiting && !abort),
        .expired (expired)
    );

    always_comb begin
        state_d           = state_q;
        pc_update         = 1'b0;
        branch            = 1'b0;
        bus.adr_src       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.result_src    = RES_ALUOUT;
        bus.alu_src_a     = SRCA_PC;
        bus.alu_src_b     = SRCB_RS2;
        bus.aluop         = ALUOP_ADD;
        bus.instr_done    = 1'b0;
        bus.illegal_instr = 1'b0;
        bus.mem_err       = 1'b0;

        case (state_q)
            S_RESET: state_d = FETCH;

            FETCH: begin
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                if (abort) begin
                    bus.mem_err = 1'b1;
                end else if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    pc_update    = 1'b1;
                    state_d      = DECODE;
                end
            end

            DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECR;
                    OP_ITYPE:     state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
                        bus.illegal_instr = 1'b1;
                        bus.instr_done    = 1'b1;
                        state_d           = FETCH;
                    end
                endcase
            end

            MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end

            MEMREAD: begin
                bus.adr_src = 1'b1;
                if (abort) begin
                    bus.mem_err = 1'b1;
                    state_d     = FETCH;
                end else if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end

            MEMWB: begin
                bus.result_src = RES_RDATA;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end

            MEMWRITE: begin
                bus.adr_src = 1'b1;
                // The write request stays up through the stall; only an abort drops it.
                if (abort) begin
                    bus.mem_err = 1'b1;
                    state_d     = FETCH;
                end else begin
                    bus.mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        bus.instr_done = 1'b1;
                        state_d        = FETCH;
                    end
                end
            end

            EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_RS2;
                bus.aluop     = ALUOP_FUNCT;
                state_d       = ALUWB;
            end

            EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                bus.aluop     = ALUOP_FUNCT;
                state_d       = ALUWB;
            end

            JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_update     = 1'b1;
                state_d       = ALUWB;
            end

            ALUWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end

            BEQ: begin
                bus.alu_src_a  = SRCA_RS1;
                bus.alu_src_b  = SRCB_RS2;
                bus.aluop      = ALUOP_SUB;
                branch         = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end

            default: state_d = FETCH;
        endcase

        bus.pc_write = pc_update || (branch && bus.zero);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: builds the expected per-cycle output trace of each
// instruction from its class and memory stall counts, then checks the DUT cycle by cycle.
module tb_multicycle_main_control;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   fails;

    multicycle_main_control_if bus ();

    multicycle_main_control #(.MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rdy_q[$];
    logic        z_q[$];
    logic [15:0] exp_q[$];
    string       tag_q[$];

    // Output vector: pc_write adr_src mem_write ir_write reg_write result_src src_a src_b aluop done ill err
    function automatic logic [15:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] res,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] aop, input logic done,
                                      input logic ill, input logic err);
        return {pcw, adr, mw, irw, rw, res, sa, sb, aop, done, ill, err};
    endfunction

    function automatic logic [15:0] obs();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.aluop,
                bus.instr_done, bus.illegal_instr, bus.mem_err};
    endfunction

    task automatic check(input string tag, input logic [15:0] expv);
        logic [15:0] o;
        o = obs();
        tests_run++;
        assert (o === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, o, expv);
        end
    endtask

    task automatic push(input logic rdy, input logic z, input logic [15:0] e, input string tag);
        rdy_q.push_back(rdy);
        z_q.push_back(z);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // kind 0 fetch, 1 load, 2 store. n >= 16 means memory never answers before the watchdog.
    task automatic mem_phase(input int kind, input int n, output bit aborted);
        int k;
        logic [15:0] base;
        k = (n >= 16) ? 15 : n;
        case (kind)
            0:       base = v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0);
            1:       base = v(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
            default: base = v(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
        endcase
        for (int i = 0; i < k; i++) push(1'b0, 1'($urandom), base, "stall");
        aborted = (n >= 16);
        if (aborted) begin
            push(1'b0, 1'($urandom), (base & ~16'h2000) | 16'h0001, "wdog_abort");
        end else if (kind == 0) begin
            push(1'b1, 1'($urandom), base | 16'h9000, "fetch");
        end else if (kind == 2) begin
            push(1'b1, 1'($urandom), base | 16'h0004, "memwrite_done");
        end else begin
            push(1'b1, 1'($urandom), base, "memread_done");
        end
    endtask

    task automatic run_q();
        while (exp_q.size() > 0) begin
            bus.mem_ready = rdy_q.pop_front();
            bus.zero      = z_q.pop_front();
            @(negedge clk);
            check(tag_q.pop_front(), exp_q.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build(input logic [6:0] op, input int fs, input int ms, input logic zb);
        bit ab;
        logic [15:0] aluwb;
        aluwb = v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0,0);
        mem_phase(0, fs, ab);
        if (ab) mem_phase(0, 0, ab);
        case (op)
            LW, SW, RT, IT, JL, BQ:
                push(1'b1, 1'($urandom), v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), "decode");
            default:
                push(1'b1, 1'($urandom), v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,1,1,0), "illegal");
        endcase
        case (op)
            LW: begin
                push(1'b1, 1'($urandom), v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0), "memadr");
                mem_phase(1, ms, ab);
                if (!ab) push(1'b1, 1'($urandom), v(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,1,0,0), "memwb");
            end
            SW: begin
                push(1'b1, 1'($urandom), v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0), "memadr");
                mem_phase(2, ms, ab);
            end
            RT: begin
                push(1'b1, 1'($urandom), v(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,0), "execr");
                push(1'b1, 1'($urandom), aluwb, "aluwb");
            end
            IT: begin
                push(1'b1, 1'($urandom), v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0,0), "execi");
                push(1'b1, 1'($urandom), aluwb, "aluwb");
            end
            JL: begin
                push(1'b1, 1'($urandom), v(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0,0), "jal");
                push(1'b1, 1'($urandom), aluwb, "aluwb");
            end
            BQ: push(1'b1, zb, v(zb,0,0,0,0,2'b00,2'b10,2'b00,2'b01,1,0,0), "beq");
            default: ;
        endcase
    endtask

    task automatic instr(input logic [6:0] op, input int fs, input int ms, input logic zb);
        int n;
        build(op, fs, ms, zb);
        n = exp_q.size();
        bus.opcode = op;
        run_q();
        $display("[TB] instr op=%b fetch_stall=%0d mem_stall=%0d zero=%b cycles=%0d",
                 op, fs, ms, zb, n);
    endtask

    initial begin
        logic [6:0] ops [6];
        bit ab;
        ops = '{LW, SW, RT, IT, JL, BQ};
        tests_run = 0;
        fails     = 0;

        rst_n         = 1'b0;
        bus.opcode    = RT;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", 16'h0000);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", 16'h0000);
        @(posedge clk);
        #1;

        instr(RT, 0, 0, 1'b0);
        instr(LW, 0, 3, 1'b0);
        instr(BQ, 0, 0, 1'b1);
        instr(BQ, 0, 0, 1'b0);
        instr(SW, 0, 16, 1'b0);
        instr(SW, 0, 15, 1'b0);
        instr(LW, 0, 16, 1'b0);
        instr(RT, 16, 0, 1'b0);
        instr(7'b1111111, 0, 0, 1'b0);
        instr(IT, 1, 0, 1'b0);
        instr(JL, 0, 0, 1'b0);

        // Reset striking mid-store must drop mem_write at once, without a clock edge.
        mem_phase(0, 0, ab);
        push(1'b1, 1'b0, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), "decode");
        push(1'b1, 1'b0, v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0), "memadr");
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, v(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0), "stall");
        bus.opcode = SW;
        run_q();
        bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", 16'h0000);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("reset_mid_hold", 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_mid_release", 16'h0000);
        @(posedge clk);
        #1;
        instr(SW, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [6:0] op;
            int fs;
            int ms;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            fs = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 3);
            ms = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 4);
            instr(op, fs, ms, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
